// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Single-port asynchronous SRAM controller, 16-bit data and
//               18-bit word address (IS61WV25616-class parts). Converts
//               one-cycle read/write strobes into sequenced CS/OE/WE pin
//               strobes and data-bus drive. The pad tristate buffer is
//               external and is controlled by data_pins_oe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WAIT_CYCLES    WE pulse width / read access window minus one (1..15)
// Configuration macro:
//   SRAM_CTRL_TURNAROUND_EN  adds a one-clock dead cycle (RD_TURN) after
//                            every read before the controller is ready again
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   address        word address, sampled when a request is accepted
//   data_write     write data, sampled when a write is accepted
//   write / read   one-cycle request strobes (write wins if both are high)
//   data_read      last word read, registered
//   ready          high when idle and able to accept a request
//   data_pins_out  data toward SRAM DQ pins
//   data_pins_in   data from SRAM DQ pins
//   data_pins_oe   high = pad drives data_pins_out onto DQ
//   sram_addr      registered address to SRAM pins
//   CS / OE / WE   active-low SRAM strobes
// ============================================================================
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] address,
  input  logic [15:0] data_write,
  input  logic        write,
  input  logic        read,
  output logic [15:0] data_read,
  output logic        ready,
  output logic [15:0] data_pins_out,
  input  logic [15:0] data_pins_in,
  output logic        data_pins_oe,
  output logic [17:0] sram_addr,
  output logic        CS,
  output logic        OE,
  output logic        WE
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_SETUP  = 3'd1,
    ST_WR_PULSE  = 3'd2,
    ST_WR_HOLD   = 3'd3,
    ST_RD_ACCESS = 3'd4,
    ST_RD_TURN   = 3'd5
  } state_t;

  // Counter reload values: the counter runs down to zero, so a window of N
  // clocks is loaded with N-1.
  localparam logic [3:0] c_pulse_load = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] c_read_load  = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept_wr;
  logic        w_accept_rd;
  logic        w_capture;

  logic [15:0] r_data_read;
  logic [15:0] r_pins_out;
  logic [17:0] r_addr;
  logic        r_ready;
  logic        r_cs_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_pins_oe;

  logic        w_ready_nxt;
  logic        w_cs_n_nxt;
  logic        w_oe_n_nxt;
  logic        w_we_n_nxt;
  logic        w_pins_oe_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept_wr = 1'b0;
    w_accept_rd = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (write) begin
          w_accept_wr = 1'b1;
          w_state_nxt = ST_WR_SETUP;
        end else if (read) begin
          w_accept_rd = 1'b1;
          w_state_nxt = ST_RD_ACCESS;
          w_cnt_nxt   = c_read_load;
        end
      end
      ST_WR_SETUP: begin
        w_state_nxt = ST_WR_PULSE;
        w_cnt_nxt   = c_pulse_load;
      end
      ST_WR_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_WR_HOLD: begin
        w_state_nxt = ST_IDLE;
      end
      ST_RD_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
          w_state_nxt = ST_RD_TURN;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RD_TURN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Pin strobes are decoded from the next state and registered, so every
    // pin changes cleanly on the clock edge that enters the state.
    w_ready_nxt   = (w_state_nxt == ST_IDLE);
    w_cs_n_nxt    = !((w_state_nxt == ST_WR_SETUP) || (w_state_nxt == ST_WR_PULSE) ||
                      (w_state_nxt == ST_WR_HOLD)  || (w_state_nxt == ST_RD_ACCESS));
    w_we_n_nxt    = (w_state_nxt != ST_WR_PULSE);
    w_oe_n_nxt    = (w_state_nxt != ST_RD_ACCESS);
    w_pins_oe_nxt = (w_state_nxt == ST_WR_SETUP) || (w_state_nxt == ST_WR_PULSE) ||
                    (w_state_nxt == ST_WR_HOLD);
  end

  // --------------------------------------------------------------------------
  // Datapath and registered pin outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_read <= 16'd0;
      r_pins_out  <= 16'd0;
      r_addr      <= 18'd0;
      r_ready     <= 1'b1;
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_pins_oe   <= 1'b0;
    end else begin
      r_ready   <= w_ready_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_pins_oe <= w_pins_oe_nxt;
      // Address/data only move on acceptance, i.e. while CS is high.
      if (w_accept_wr || w_accept_rd) begin
        r_addr <= address;
      end
      if (w_accept_wr) begin
        r_pins_out <= data_write;
      end
      if (w_capture) begin
        r_data_read <= data_pins_in;
      end
    end
  end

  assign data_read     = r_data_read;
  assign ready         = r_ready;
  assign data_pins_out = r_pins_out;
  assign data_pins_oe  = r_pins_oe;
  assign sram_addr     = r_addr;
  assign CS            = r_cs_n;
  assign OE            = r_oe_n;
  assign WE            = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Scoreboard bench for sram_ctrl. A behavioural SRAM model sits
//               on the pins; issued requests push their expected transaction
//               profile (strobe widths, latency, address/data, data_read)
//               into a queue that an independent monitor pops and checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

  localparam int W = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int RD_LAT = W + 2;
`else
  localparam int RD_LAT = W + 1;
`endif

  logic        clk;
  logic        reset;
  logic [17:0] address;
  logic [15:0] data_write;
  logic        write;
  logic        read;
  logic [15:0] data_read;
  logic        ready;
  logic [15:0] data_pins_out;
  logic [15:0] data_pins_in;
  logic        data_pins_oe;
  logic [17:0] sram_addr;
  logic        CS, OE, WE;

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .address(address), .data_write(data_write),
    .write(write), .read(read), .data_read(data_read), .ready(ready),
    .data_pins_out(data_pins_out), .data_pins_in(data_pins_in),
    .data_pins_oe(data_pins_oe), .sram_addr(sram_addr),
    .CS(CS), .OE(OE), .WE(WE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural SRAM on the pins ----------------
  logic [15:0] sram_mem [0:63];
  logic        pin_force;
  logic [15:0] pin_val;

  assign data_pins_in = pin_force ? pin_val :
                        ((!CS && !OE) ? sram_mem[sram_addr[5:0]] : 16'hDEAD);

  always @(posedge clk) begin
    if (!CS && !WE) sram_mem[sram_addr[5:0]] <= data_pins_out;
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          lat;
    int          cs;
    int          we;
    int          oe;
    int          dq;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] ref_mem [0:63];
  logic [15:0] ref_last_read;

  // kind: 0 = write, 1 = read, 2 = write and read together
  task automatic do_op(input int kind, input logic [17:0] a, input logic [15:0] d);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    e.addr = a;
    if (kind != 1) begin
      e.wdata  = d;
      e.exp_rd = ref_last_read;
      e.lat = W + 2; e.cs = W + 2; e.we = W; e.oe = 0; e.dq = W + 2;
      ref_mem[a[5:0]] = d;
    end else begin
      e.wdata  = 16'hxxxx;
      e.exp_rd = pin_force ? pin_val : ref_mem[a[5:0]];
      e.lat = RD_LAT; e.cs = W + 1; e.we = 0; e.oe = W + 1; e.dq = 0;
      ref_last_read = e.exp_rd;
    end
    sb_q.push_back(e);
    address    = a;
    data_write = d;
    write      = (kind != 1);
    read       = (kind != 0);
    @(posedge clk);
    #1;
    write      = 1'b0;
    read       = 1'b0;
    address    = 18'($urandom);
    data_write = 16'($urandom);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t cur;
    bit   in_txn, have;
    bit   v_prot, v_addr, v_data;
    int   n_lat, n_cs, n_we, n_oe, n_dq;
    in_txn = 0; have = 0;
    v_prot = 0; v_addr = 0; v_data = 0;
    n_lat = 0; n_cs = 0; n_we = 0; n_oe = 0; n_dq = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb_q.delete();
        in_txn = 0;
      end else if (!ready) begin
        if (!in_txn) begin
          in_txn = 1;
          n_lat = 0; n_cs = 0; n_we = 0; n_oe = 0; n_dq = 0;
          v_prot = 0; v_addr = 0; v_data = 0;
          if (sb_q.size() == 0) begin
            have = 0;
            check("unexpected_txn", 32'd1, 32'd0);
          end else begin
            cur  = sb_q.pop_front();
            have = 1;
          end
        end
        n_lat++;
        if (!CS) n_cs++;
        if (!WE) n_we++;
        if (!OE) n_oe++;
        if (data_pins_oe) n_dq++;
        if ((!OE && data_pins_oe) || (!WE && !data_pins_oe)) v_prot = 1;
        if (have && !CS && sram_addr !== cur.addr) v_addr = 1;
        if (have && !WE && data_pins_out !== cur.wdata) v_data = 1;
      end else if (in_txn) begin
        in_txn = 0;
        if (have) begin
          check("latency",     32'(n_lat), 32'(cur.lat));
          check("cs_low_clks", 32'(n_cs),  32'(cur.cs));
          check("we_low_clks", 32'(n_we),  32'(cur.we));
          check("oe_low_clks", 32'(n_oe),  32'(cur.oe));
          check("dq_drv_clks", 32'(n_dq),  32'(cur.dq));
          check("pin_protocol", 32'(v_prot), 32'd0);
          check("addr_stable",  32'(v_addr), 32'd0);
          check("wdata_stable", 32'(v_data), 32'd0);
          check("data_read",    32'(data_read), 32'(cur.exp_rd));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] r;
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = 16'd0;
      ref_mem[i]  = 16'd0;
    end
    ref_last_read = 16'd0;
    pin_force = 1'b0; pin_val = 16'd0;
    write = 1'b0; read = 1'b0; address = 18'd0; data_write = 16'd0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_cs",    32'(CS), 32'd1);
    check("rst_oe",    32'(OE), 32'd1);
    check("rst_we",    32'(WE), 32'd1);
    check("rst_dq_oe", 32'(data_pins_oe), 32'd0);
    check("rst_data_read", 32'(data_read), 32'd0);
    check("rst_pins_out",  32'(data_pins_out), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Directed: write 0xAAAA to address 0.
    do_op(0, 18'd0, 16'hAAAA);
    // Directed: read with DQ pins held at 0x0A0A.
    wait_ready();
    pin_force = 1'b1; pin_val = 16'h0A0A;
    do_op(1, 18'd0, 16'h0000);
    wait_ready();
    pin_force = 1'b0;
    // Write and read together: write only, data_read unchanged.
    do_op(2, 18'h2_0005, 16'h1234);
    // Read strobe during an active write is ignored.
    do_op(0, 18'h1_0007, 16'hBEEF);
    @(negedge clk);
    read = 1'b1; address = 18'd9;
    @(posedge clk);
    #1 read = 1'b0;
    wait_ready();

    // Reset in the middle of WR_PULSE.
    do_op(0, 18'h3_FFFF, 16'h5A5A);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_we",    32'(WE), 32'd1);
    check("abort_cs",    32'(CS), 32'd1);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_dq_oe", 32'(data_pins_oe), 32'd0);
    check("abort_data_read", 32'(data_read), 32'd0);
    ref_last_read = 16'd0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    do_op(1, 18'd0, 16'h0000);

    // Random traffic; addresses use low index 0..62 so slot 63 (aborted
    // write) is never read back.
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      do_op(int'($urandom_range(0, 2)),
            {r[17:6], 6'($urandom_range(0, 62))}, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_ready();
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
